// File: rtl/imem_program_loader_if.sv
// Byte-stream and instruction-memory write bus for the program loader.
// The master side feeds bytes and start; the slave side is the loader.
interface imem_program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [31:0]           imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_rst;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded
  );
endinterface

// File: rtl/imem_program_loader.sv
// Fills instruction memory from a length-prefixed, XOR-checksummed byte stream
// and holds the CPU in reset until a verified image is in place.
module imem_program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  imem_program_loader_if.slave  bus
);
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t        state_q;
  logic [7:0]    len_hi_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] wl_q;
  logic [1:0]    bcnt_q;
  logic [23:0]   sr_q;
  logic [7:0]    xor_q;
  logic          in_ready_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          cpu_rst_q;
  logic          done_q;
  logic          error_q;

  logic          xfer;
  logic [16:0]   n_full;
  logic          len_bad;
  logic [CW-1:0] wl_d;
  logic [7:0]    xor_d;

  assign xfer    = bus.in_valid && in_ready_q;
  assign n_full  = {1'b0, len_hi_q, bus.in_data};
  // 2^ADDR_WIDTH words is legal: it fills memory exactly
  assign len_bad = n_full > (17'd1 << ADDR_WIDTH);
  assign wl_d    = wl_q + CW'(1);
  assign xor_d   = xor_q ^ bus.in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_hi_q   <= '0;
      n_q        <= '0;
      wl_q       <= '0;
      bcnt_q     <= '0;
      sr_q       <= '0;
      xor_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state_q    <= S_LEN_HI;
            in_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            wl_q       <= '0;
            bcnt_q     <= '0;
            xor_q      <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= bus.in_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            n_q <= CW'(n_full);
            if (len_bad) begin
              state_q    <= S_ERROR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else if (n_full == 17'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            xor_q  <= xor_d;
            bcnt_q <= bcnt_q + 2'd1;
            sr_q   <= {sr_q[15:0], bus.in_data};
            // 4th byte completes the word; first byte received lands in [31:24]
            if (bcnt_q == 2'd3) begin
              we_q    <= 1'b1;
              wdata_q <= {sr_q, bus.in_data};
              addr_q  <= 32'({wl_q, 2'b00});
              wl_q    <= wl_d;
              if (wl_d == n_q) state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == xor_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.cpu_rst      = cpu_rst_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.words_loaded = wl_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Table-driven and randomized checks of the program loader against a
// stream-level reference model (parse length, words, checksum).
module tb_imem_program_loader;
  localparam int AW = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          wl;
    int          cyc;
  } wr_t;
  typedef struct {
    string       name;
    int          len;
    logic [7:0]  b[12];
    bit          e_done;
    bit          e_err;
    int          e_words;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_program_loader_if #(.ADDR_WIDTH(AW)) bus();
  imem_program_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  bit  m_done, m_err;
  int  m_words;

  always @(negedge clk) begin
    cyc++;
    if (bus.imem_we === 1'b1)
      got_q.push_back('{addr: bus.imem_addr, data: bus.imem_wdata,
                        wl: int'(bus.words_loaded), cyc: cyc});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: interpret the stream directly from the format rules.
  task automatic model(input bq_t s);
    int n;
    logic [7:0] x;
    exp_q.delete();
    m_done = 0; m_err = 0; m_words = 0;
    n = int'(s[0]) * 256 + int'(s[1]);
    if (n > (1 << AW)) begin
      m_err = 1;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_q.push_back('{addr: 32'(4 * w),
                        data: {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]},
                        wl: w + 1, cyc: 0});
      for (int k = 0; k < 4; k++) x ^= s[2 + 4*w + k];
    end
    m_words = n;
    m_done  = (s[2 + 4*n] == x);
    m_err   = !m_done;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({nm, "_we"},       64'(bus.imem_we), 64'd0);
    chk({nm, "_addr"},     64'(bus.imem_addr), 64'd0);
    chk({nm, "_wdata"},    64'(bus.imem_wdata), 64'd0);
    chk({nm, "_cpu_rst"},  64'(bus.cpu_rst), 64'd1);
    chk({nm, "_done"},     64'(bus.done), 64'd0);
    chk({nm, "_error"},    64'(bus.error), 64'd0);
    chk({nm, "_words"},    64'(bus.words_loaded), 64'd0);
  endtask

  task automatic do_start(input string nm);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "_start_ready"},  64'(bus.in_ready), 64'd1);
    chk({nm, "_start_cpurst"}, 64'(bus.cpu_rst), 64'd1);
  endtask

  // mode 0: continuous valid; 1: valid every other cycle; 2: random valid.
  // Modes 1/2 also throw stray start pulses at the loader mid-load.
  task automatic send(input bq_t s, input int mode, output bit ok);
    int idx = 0;
    int guard = 0;
    bit v, x;
    ok = 1;
    while (idx < s.size()) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = 1'(($urandom_range(0, 1)));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? s[idx] : 8'($urandom);
      bus.start    = (mode != 0) && ($urandom_range(0, 3) == 0);
      x = v && bus.in_ready;
      @(posedge clk);
      if (x) idx++;
      guard++;
      if (guard > 6000) begin
        ok = 0;
        break;
      end
    end
  endtask

  task automatic run_stream(input string nm, input bq_t s, input int mode);
    bit ok;
    int n;
    model(s);
    do_start(nm);
    got_q.delete();
    send(s, mode, ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk({nm, "_no_timeout"}, 64'(ok), 64'd1);
    chk({nm, "_done"},     64'(bus.done), 64'(m_done));
    chk({nm, "_error"},    64'(bus.error), 64'(m_err));
    chk({nm, "_cpu_rst"},  64'(bus.cpu_rst), 64'(!m_done));
    chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({nm, "_words"},    64'(bus.words_loaded), 64'(m_words));
    chk({nm, "_nwrites"},  64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({nm, "_waddr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      chk({nm, "_wdata"}, 64'(got_q[i].data), 64'(exp_q[i].data));
      chk({nm, "_wwl"},   64'(got_q[i].wl),   64'(exp_q[i].wl));
    end
  endtask

  vec_t vecs[5];

  initial begin
    bq_t s;
    bit  ok;
    vecs[0] = '{"load",   11, '{8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20,8'h55,8'h00}, 1, 0, 2};
    vecs[1] = '{"badsum", 11, '{8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20,8'h54,8'h00}, 0, 1, 2};
    vecs[2] = '{"empty",   3, '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 0, 0};
    vecs[3] = '{"oversz",  2, '{8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 1, 0};
    vecs[4] = '{"oneword", 7, '{8'h00,8'h01,8'hDE,8'hAD,8'hBE,8'hEF,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 0, 1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      s.delete();
      for (int j = 0; j < vecs[i].len; j++) s.push_back(vecs[i].b[j]);
      run_stream(vecs[i].name, s, 0);
      chk({vecs[i].name, "_tbl_done"},  64'(bus.done), 64'(vecs[i].e_done));
      chk({vecs[i].name, "_tbl_error"}, 64'(bus.error), 64'(vecs[i].e_err));
      chk({vecs[i].name, "_tbl_words"}, 64'(bus.words_loaded), 64'(vecs[i].e_words));
      if (i == 0 && got_q.size() == 2) begin
        chk("load_w0", {got_q[0].addr, got_q[0].data}, {32'h0, 32'h20080005});
        chk("load_w1", {got_q[1].addr, got_q[1].data}, {32'h4, 32'h01095020});
        chk("load_w_spacing", 64'(got_q[1].cyc - got_q[0].cyc), 64'd4);
      end
    end

    // Bursty source with stray start pulses: same outcome as the clean load
    s.delete();
    for (int j = 0; j < 11; j++) s.push_back(vecs[0].b[j]);
    run_stream("bursty", s, 1);

    // Reset after 5 data bytes, then a clean reload must not see stale data
    do_start("midrst");
    s.delete();
    for (int j = 0; j < 7; j++) s.push_back(vecs[0].b[j]);
    send(s, 0, ok);
    chk("midrst_sent", 64'(ok), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("midrst");
    s.delete();
    for (int j = 0; j < 11; j++) s.push_back(vecs[0].b[j]);
    run_stream("rerun", s, 0);

    // Exactly-full memory
    s.delete();
    begin
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      s.push_back(8'h01); s.push_back(8'h00);
      for (int j = 0; j < 4 * (1 << AW); j++) begin
        b = 8'($urandom);
        x ^= b;
        s.push_back(b);
      end
      s.push_back(x);
    end
    run_stream("full", s, 0);

    // Randomized streams checked only against the model
    for (int t = 0; t < 30; t++) begin
      int n;
      logic [7:0] x;
      logic [7:0] b;
      s.delete();
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range((1 << AW) + 1, 65535);
        s.push_back(8'(n >> 8)); s.push_back(8'(n));
      end else begin
        n = $urandom_range(0, 6);
        x = 8'h00;
        s.push_back(8'(n >> 8)); s.push_back(8'(n));
        for (int j = 0; j < 4 * n; j++) begin
          b = 8'($urandom);
          x ^= b;
          s.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
        s.push_back(x);
      end
      run_stream($sformatf("rand%0d", t), s, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction-memory read path: the pipeline only fetches from instruction memory, and this block fills it.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instructions and issues single-cycle write strobes into instruction memory at word-aligned byte addresses (PC addressing).
- Holds the pipeline in reset via cpu_rst until a complete, checksum-verified image has been written.

Parameters:
- ADDR_WIDTH, 8, word-address bits of instruction memory; capacity = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a load; sampled in IDLE, DONE, ERROR only
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  32  byte address of the write = word_index<<2
- imem_wdata  output  32  assembled instruction
- cpu_rst  output  1  pipeline reset hold
- done  output  1  image loaded and verified
- error  output  1  load failed
- words_loaded  output  ADDR_WIDTH+1  words written in the current load

Behaviour:
- Handshake: a byte transfers on a cycle where in_valid && in_ready. Only transferred bytes advance state.
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N*4 instruction bytes; the first byte of each word maps to [31:24].
  - One checksum byte = XOR of all instruction bytes. When N=0 the expected checksum is 0x00.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
  - IDLE: wait for start, then go to LEN_HI. Clear words_loaded, the byte counter and the running XOR.
  - LEN_HI: on transfer, latch the high byte and go to LEN_LO.
  - LEN_LO: on transfer, form N.
    - If N > 2^ADDR_WIDTH, go to ERROR.
    - Else if N==0, go to CSUM.
    - Else go to DATA.
  - DATA: a 2-bit byte counter shifts bytes into a word register and XORs each byte into the checksum. On the 4th byte, capture the word and the write address. After the Nth word, go to CSUM.
  - CSUM: on transfer, go to DONE if the byte equals the running XOR, else go to ERROR.
  - DONE / ERROR: hold until start, which behaves as from IDLE (new load from address 0).
- start is ignored in LEN_HI/LEN_LO/DATA/CSUM.
- in_ready is registered: 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 in IDLE, DONE, ERROR. It drops the cycle after the final checksum transfer or the length error.
- Write timing:
  - imem_we is high for exactly one cycle, the cycle after the 4th byte of a word transfers.
  - imem_addr and imem_wdata are valid in that cycle and held until the next write.
  - words_loaded increments in that same cycle.
  - Back-to-back words (continuous valid) produce strobes every 4 cycles.
- cpu_rst is 1 in every state except DONE. It deasserts the cycle DONE is entered and reasserts when a new load starts.
- done = (state==DONE); error = (state==ERROR). Both are registered.
- Writes made before a checksum failure are not undone; error plus cpu_rst keep the CPU halted.
- Arithmetic: the word index is ADDR_WIDTH+1 bits; N = 2^ADDR_WIDTH is legal and fills memory exactly. Address bits [1:0] are always 0 and bits above ADDR_WIDTH+1 are 0.
- Reset (any state, including mid-word):
  - state = IDLE.
  - in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0.
  - cpu_rst 1, done 0, error 0, words_loaded 0.
  - Partial word, XOR and count are discarded.

Test Plan:
- Load, continuous valid: start; bytes 00 02 20 08 00 05 01 09 50 20 55.
  - imem_we pulses at addr 0x0 data 0x20080005 and addr 0x4 data 0x01095020.
  - Then done=1, cpu_rst=0, words_loaded=2, in_ready=0.
- Bad checksum: same stream with last byte 0x54.
  - Both writes still occur, then error=1, done=0, cpu_rst=1.
- Empty image: start; bytes 00 00 00.
  - No imem_we pulse, done=1, cpu_rst=0, words_loaded=0.
- Oversize (ADDR_WIDTH=8): start; bytes 01 01.
  - error=1 the cycle after LEN_LO, in_ready=0, no writes.
  - A following start begins a fresh load from address 0.
- Bursty source: the test 1 stream with in_valid toggling every other cycle and random cycles of start=1 mid-load.
  - Identical writes and final outputs; start has no effect.
- Reset mid-load: rst for one cycle after 5 data bytes.
  - All outputs at reset values.
  - Rerun of test 1 writes 0x20080005 at addr 0x0 (no stale partial word) and reaches done.
